trace_packetizer: RTL

TRACE_PACKETIZER -- requirements
Module: trace_packetizer

---
 rtl/trace_pkg.sv | 19 +
 rtl/trace_packetizer_if.sv | 31 +++
 rtl/pkt_ram.sv | 43 ++++
 rtl/trace_packetizer.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// trace_pkg: shared constants and types for the trace packetizer.
//   TRACE_WORD_W    - trace word width in bits
//   TRACE_PKT_WORDS - words per packet; the sender always emits 16 bytes
//   TRACE_NPKTS     - default number of packet slots
//   word_t          - one trace word
//   sat_inc8        - 8-bit increment that sticks at 255
package trace_pkg;

    localparam int TRACE_WORD_W    = 16;
    localparam int TRACE_PKT_WORDS = 8;
    localparam int TRACE_NPKTS     = 4;

    typedef logic [TRACE_WORD_W-1:0] word_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/trace_packetizer_if.sv
// trace_packetizer_if: groups the trace input side and the packet output
// side of the packetizer.
//   sync, WdAvail, TraceWd              - trace deserialiser -> packetizer
//   PacketNext, PacketNextWd            - sender -> packetizer strobes
//   PacketAvail, PacketOut              - packetizer -> sender
//   Overflow, DropCount                 - drop reporting
// Modports: master drives the inputs (deserialiser/sender side),
//           slave is the packetizer itself.
interface trace_packetizer_if;

    logic              sync;
    logic              WdAvail;
    trace_pkg::word_t  TraceWd;
    logic              PacketAvail;
    logic              PacketNext;
    logic              PacketNextWd;
    trace_pkg::word_t  PacketOut;
    logic              Overflow;
    logic [7:0]        DropCount;

    modport master (
        output sync, WdAvail, TraceWd, PacketNext, PacketNextWd,
        input  PacketAvail, PacketOut, Overflow, DropCount
    );

    modport slave (
        input  sync, WdAvail, TraceWd, PacketNext, PacketNextWd,
        output PacketAvail, PacketOut, Overflow, DropCount
    );

endinterface

// File: rtl/pkt_ram.sv
// pkt_ram: simple dual-port packet store, one write port and one
// registered read port.
//   clk, rst          - clock, synchronous active-low reset (read register only)
//   we_i/waddr_i/wdata_i - write port
//   re_i/raddr_i      - read enable/address; data appears on rdata_o
//                       after the edge and holds until the next read
//   rdata_o           - registered read data
module pkt_ram #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Storage is deliberately not reset; only the output register is.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/trace_packetizer.sv
// trace_packetizer: collects 16-bit trace words into fixed-size packets in
// a ring of NPKTS slots and hands complete packets to a byte sender in
// FIFO order.
//   clk, rst - clock, synchronous active-low reset
//   bus      - trace_packetizer_if.slave (trace input, sender strobes,
//              PacketAvail/PacketOut, Overflow/DropCount)
// One slot is always kept free for writing, so a packet is committed only
// while (complete unclaimed + claimed) < NPKTS-1; otherwise it is dropped.
module trace_packetizer
    import trace_pkg::*;
#(
    parameter int NPKTS     = TRACE_NPKTS,
    parameter int PKT_WORDS = TRACE_PKT_WORDS
) (
    input logic               clk,
    input logic               rst,
    trace_packetizer_if.slave bus
);

    localparam int PKT_W  = $clog2(NPKTS);
    localparam int WD_W   = $clog2(PKT_WORDS);
    localparam int RD_W   = $clog2(PKT_WORDS + 1);
    localparam int ADDR_W = PKT_W + WD_W;

    logic [PKT_W-1:0] wr_pkt_q, wr_pkt_d;
    logic [WD_W-1:0]  wr_wd_q, wr_wd_d;
    logic [PKT_W-1:0] rd_pkt_q, rd_pkt_d;
    logic [RD_W-1:0]  rd_wd_q, rd_wd_d;
    logic [PKT_W-1:0] cnt_q, cnt_d;
    logic             claimed_q, claimed_d;
    logic             avail_q;
    logic             ovf_q, ovf_d;
    logic [7:0]       drop_q, drop_d;

    logic wr_en, last_wd, commit, drop, claim, rd_en;

    always_comb begin
        wr_en   = bus.sync && bus.WdAvail;
        last_wd = wr_en && (wr_wd_q == WD_W'(PKT_WORDS - 1));
        commit  = last_wd && ((int'(cnt_q) + int'(claimed_q)) < (NPKTS - 1));
        drop    = last_wd && !commit;
        claim   = bus.PacketNext && (cnt_q != '0);
        // PacketNext takes priority over a coincident PacketNextWd.
        rd_en   = !bus.PacketNext && bus.PacketNextWd && claimed_q
                  && (rd_wd_q < RD_W'(PKT_WORDS));
    end

    always_comb begin
        wr_pkt_d  = wr_pkt_q;
        wr_wd_d   = wr_wd_q;
        rd_pkt_d  = rd_pkt_q;
        rd_wd_d   = rd_wd_q;
        cnt_d     = cnt_q;
        claimed_d = claimed_q;
        ovf_d     = drop;
        drop_d    = drop_q;

        if (!bus.sync) begin
            wr_wd_d = '0;
        end else if (bus.WdAvail) begin
            if (last_wd) begin
                wr_wd_d = '0;
                if (commit) begin
                    wr_pkt_d = wr_pkt_q + PKT_W'(1);
                end
            end else begin
                wr_wd_d = wr_wd_q + WD_W'(1);
            end
        end

        if (drop) begin
            drop_d = sat_inc8(drop_q);
        end

        // Oldest complete slot sits cnt_q slots behind the write slot; a
        // commit in the same cycle lands at wr_pkt_q and does not move it.
        if (bus.PacketNext) begin
            if (claim) begin
                claimed_d = 1'b1;
                rd_pkt_d  = wr_pkt_q - cnt_q;
                rd_wd_d   = '0;
            end else begin
                claimed_d = 1'b0;
            end
        end else if (rd_en) begin
            rd_wd_d = rd_wd_q + RD_W'(1);
        end

        if (commit && !claim) begin
            cnt_d = cnt_q + PKT_W'(1);
        end else if (claim && !commit) begin
            cnt_d = cnt_q - PKT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_pkt_q  <= '0;
            wr_wd_q   <= '0;
            rd_pkt_q  <= '0;
            rd_wd_q   <= '0;
            cnt_q     <= '0;
            claimed_q <= 1'b0;
            avail_q   <= 1'b0;
            ovf_q     <= 1'b0;
            drop_q    <= '0;
        end else begin
            wr_pkt_q  <= wr_pkt_d;
            wr_wd_q   <= wr_wd_d;
            rd_pkt_q  <= rd_pkt_d;
            rd_wd_q   <= rd_wd_d;
            cnt_q     <= cnt_d;
            claimed_q <= claimed_d;
            avail_q   <= (cnt_q != '0);
            ovf_q     <= ovf_d;
            drop_q    <= drop_d;
        end
    end

    logic [ADDR_W-1:0] waddr, raddr;
    word_t             rdata;

    assign waddr = {wr_pkt_q, wr_wd_q};
    assign raddr = {rd_pkt_q, rd_wd_q[WD_W-1:0]};

    pkt_ram #(
        .DEPTH  (NPKTS * PKT_WORDS),
        .ADDR_W (ADDR_W),
        .DATA_W (TRACE_WORD_W)
    ) u_pkt_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (wr_en),
        .waddr_i (waddr),
        .wdata_i (bus.TraceWd),
        .re_i    (rd_en),
        .raddr_i (raddr),
        .rdata_o (rdata)
    );

    assign bus.PacketAvail = avail_q;
    assign bus.PacketOut   = rdata;
    assign bus.Overflow    = ovf_q;
    assign bus.DropCount   = drop_q;

endmodule
